// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester initiator for the shared data memory.
// Each core holds a request (read or write) until it receives a one-cycle
// acknowledge. Requests are serialized onto the single memory port with a
// three-state FSM: IDLE (arbitrate and latch) -> ISSUE (memory access) ->
// RESP (ack/err pulse).
//
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   : ties are broken round-robin via last_grant_q (port 0 first)
//   undefined : fixed priority, port 0 always wins ties
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req0/1, we0/1       held request, 1 = write / 0 = read
//   addr0/1, wdata0/1   word address and write data, stable while req is high
//   ack0/1              one-cycle completion pulse
//   rdata0/1            read data, valid while ack is high, held otherwise
//   err0/1              pulses with ack when the address was out of range
//   mem_we, mem_addr,   memory write enable, address, write data
//   mem_din
//   mem_dout            combinational memory read data
module dmem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          cur_id_q;
  logic          cur_we_q;
  logic [AW-1:0] cur_addr_q;
  logic [DW-1:0] cur_wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          any_req;
  logic          grant_id;
  logic          grant;
  logic          in_range;

  assign any_req  = req0 | req1;
  assign grant    = (state_q == IDLE) && any_req;
  assign in_range = (cur_addr_q >> DEPTH_LOG2) == '0;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Remembers the most recent grant; reset to 1 so port 0 wins the first tie.
  logic last_grant_q;

  always_comb begin
    grant_id = ~req0;
    if (req0 && req1) begin
      grant_id = ~last_grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (grant) begin
      last_grant_q <= grant_id;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting.
  always_comb begin
    grant_id = ~req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The current-access registers double as the memory address/data drivers,
  // so mem_addr/mem_din only change when a new access is latched and hold
  // their value through RESP and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_id_q    <= 1'b0;
      cur_we_q    <= 1'b0;
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      if (grant) begin
        cur_id_q    <= grant_id;
        cur_we_q    <= grant_id ? we1 : we0;
        cur_addr_q  <= grant_id ? addr1 : addr0;
        cur_wdata_q <= grant_id ? wdata1 : wdata0;
      end
      // Read data is captured at the edge ending ISSUE; out-of-range reads
      // return zero instead of whatever the memory aliases to.
      if ((state_q == ISSUE) && !cur_we_q) begin
        if (cur_id_q) begin
          rdata1_q <= in_range ? mem_dout : '0;
        end else begin
          rdata0_q <= in_range ? mem_dout : '0;
        end
      end
    end
  end

  // All memory-side controls decode from registered state only, so they
  // never glitch on core input changes.
  assign mem_we   = (state_q == ISSUE) && cur_we_q && in_range;
  assign mem_addr = cur_addr_q;
  assign mem_din  = cur_wdata_q;

  assign ack0   = (state_q == RESP) && !cur_id_q;
  assign ack1   = (state_q == RESP) &&  cur_id_q;
  assign err0   = ack0 && !in_range;
  assign err1   = ack1 && !in_range;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed transactions against a transaction-
// timeline model of the arbiter and a model of the shared memory, compared
// every cycle, plus literal expectations for latency, grant order and data.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DL = 8;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(DW), .AW(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  // Memory seen by the DUT: synchronous write, combinational read. Reads
  // beyond the implemented depth return a marker the DUT must not forward.
  logic [DW-1:0] tb_mem [0:255];
  assign mem_dout = (mem_addr < 256) ? tb_mem[mem_addr[7:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (mem_we === 1'b1 && mem_addr < 256) tb_mem[mem_addr[7:0]] <= mem_din;
  end

  // Reference model: an access is granted in an idle cycle, touches memory
  // one cycle later (age 1) and is acknowledged the cycle after (age 2).
  logic [DW-1:0] ref_mem [0:255];
  int            m_age;
  logic          m_port, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd0, m_rd1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  <= pat(i);
      ref_mem[i] <= pat(i);
    end
  end

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return RR ? !last : 1'b0;
    return !r0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age <= 0; m_port <= 1'b0; m_we <= 1'b0; m_last <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_rd0 <= '0; m_rd1 <= '0;
    end else if (m_age == 1) begin
      if (m_we && m_addr < 256) ref_mem[m_addr[7:0]] <= m_wdata;
      if (!m_we && m_port)  m_rd1 <= (m_addr < 256) ? ref_mem[m_addr[7:0]] : '0;
      if (!m_we && !m_port) m_rd0 <= (m_addr < 256) ? ref_mem[m_addr[7:0]] : '0;
      m_age <= 2;
    end else if (m_age == 2) begin
      m_age <= 0;
    end else if (req0 || req1) begin
      m_port  <= pick(req0, req1, m_last);
      m_last  <= pick(req0, req1, m_last);
      m_we    <= pick(req0, req1, m_last) ? we1 : we0;
      m_addr  <= pick(req0, req1, m_last) ? addr1 : addr0;
      m_wdata <= pick(req0, req1, m_last) ? wdata1 : wdata0;
      m_age   <= 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack0",     32'(ack0),   32'(m_age == 2 && !m_port));
      check("ack1",     32'(ack1),   32'(m_age == 2 &&  m_port));
      check("err0",     32'(err0),   32'(m_age == 2 && !m_port && m_addr >= 256));
      check("err1",     32'(err1),   32'(m_age == 2 &&  m_port && m_addr >= 256));
      check("mem_we",   32'(mem_we), 32'(m_age == 1 && m_we && m_addr < 256));
      check("mem_addr", mem_addr, m_addr);
      check("mem_din",  mem_din,  m_wdata);
      check("rdata0",   rdata0,   m_rd0);
      check("rdata1",   rdata1,   m_rd1);
    end
  end

  // One transaction on a port; returns at the negedge where ack is seen.
  task automatic txn(input bit port, input logic we, input logic [31:0] addr,
                     input logic [31:0] data, output int lat, output int wes,
                     output logic errv);
    @(negedge clk);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    lat = -1; wes = 0; errv = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_we === 1'b1) wes++;
      if ((port ? ack1 : ack0) === 1'b1) begin
        lat = n; errv = port ? err1 : err0;
        break;
      end
    end
    if (lat < 0) check("txn_timeout", 32'd0, 32'd1);
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    int lat, wes, n, acks;
    logic e;
    int order [4];
    int exp_order [4];
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Write 0xDEADBEEF to word 5 from port 0.
    txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, wes, e);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_we_cycles", 32'(wes), 32'd1);
    check("wr_err", 32'(e), 32'd0);
    check("wr_word5", tb_mem[5], 32'hDEAD_BEEF);

    // Read word 5 back on port 1.
    txn(1'b1, 1'b0, 32'd5, 32'd0, lat, wes, e);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_we_cycles", 32'(wes), 32'd0);
    check("rd_rdata1", rdata1, 32'hDEAD_BEEF);

    // Both ports requesting continuously, four accesses.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
    acks = 0;
    for (n = 0; n < 40 && acks < 4; n++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin order[acks] = 0; acks++; end
      else if (ack1 === 1'b1) begin order[acks] = 1; acks++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_acks", 32'(acks), 32'd4);
    exp_order = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) check($sformatf("grant_%0d", i), 32'(order[i]), 32'(exp_order[i]));
    check("tie_rdata0", rdata0, 32'h100A_000A);

    // Out-of-range write then read at 0x100.
    txn(1'b0, 1'b1, 32'h100, 32'h1234_5678, lat, wes, e);
    check("oor_wr_err", 32'(e), 32'd1);
    check("oor_wr_we", 32'(wes), 32'd0);
    txn(1'b0, 1'b0, 32'h100, 32'd0, lat, wes, e);
    check("oor_rd_err", 32'(e), 32'd1);
    check("oor_rd_rdata0", rdata0, 32'd0);

    // Reset during ISSUE of a write to word 7; request stays held.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h7777_7777;
    @(posedge clk);
    #2 rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1) acks++;
    end
    check("rstmid_no_ack", 32'(acks), 32'd0);
    check("rstmid_word7", tb_mem[7], 32'h1007_0007);
    check("rstmid_mem_we", 32'(mem_we), 32'd0);
    check("rstmid_rdata1", rdata1, 32'd0);
    rst = 1'b0;
    lat = -1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin lat = n; break; end
    end
    req0 = 1'b0;
    check("rstmid_lat", 32'(lat), 32'd2);
    check("rstmid_word7_after", tb_mem[7], 32'h7777_7777);

    // Back-to-back reads of words 3 and 4 with req0 held high.
    txn(1'b0, 1'b0, 32'd3, 32'd0, lat, wes, e);
    check("b2b_lat0", 32'(lat), 32'd2);
    check("b2b_rd3", rdata0, 32'h1003_0003);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
    lat = -1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin lat = n; break; end
    end
    req0 = 1'b0;
    check("b2b_gap", 32'(lat), 32'd3);
    check("b2b_rd4", rdata0, 32'h1004_0004);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
